mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Clocked memory responder at the far end of the control path's memory request channel.
//  Accepts 4-phase bundled-data requests: mem_req = read, mem_req_ghost = bubble (no read).
//  For a read, returns the word at mem_addr_in on mem_data_out, then raises mem_ack.
//  Lets the data path and control path run against a synchronous coefficient store.
// PARAMETERS
//  DATA_WIDTH    16  width of stored words / mem_data_out
//  ADDR_WIDTH     4  address width, equal to ARBITER_SEL_WIDTH; DEPTH = 2**ADDR_WIDTH
//  READ_LATENCY   2  cycles spent in READ before ack (legal range 1..15)
//  COUNT_WIDTH    8  width of read_count
// PORTS
//  clk            in   1           single clock
//  rst            in   1           synchronous, active-high reset
//  mem_req        in   1           read request (4-phase, may be asynchronous)
//  mem_req_ghost  in   1           ghost request: ack without reading
//  mem_addr_in    in   ADDR_WIDTH  read address, bundled with mem_req
//  mem_ack        out  1           acknowledge
//  mem_data_out   out  DATA_WIDTH  read data, valid while mem_ack=1
//  load_en        in   1           synchronous write strobe (init/bench port)
//  load_addr      in   ADDR_WIDTH  write address
//  load_data      in   DATA_WIDTH  write data
//  busy           out  1           state != IDLE
//  proto_err      out  1           sticky: mem_req and mem_req_ghost both high
//  read_count     out  COUNT_WIDTH completed reads, wraps at 2**COUNT_WIDTH
// BEHAVIOUR
//  - Reset values: mem_ack=0, mem_data_out=0, busy=0, proto_err=0, read_count=0, state=IDLE.
//    Memory array is not reset.
//  - s_req and s_ghost are the sampled request inputs (see CONFIGURATION).
//  - FSM, states IDLE, READ, ACK:
//    IDLE, s_req&s_ghost: set proto_err, stay in IDLE, no ack.
//    IDLE, s_req only: latch mem_addr_in into addr_q, load cnt=READ_LATENCY-1, go to READ.
//    IDLE, s_ghost only: mem_ack<=1, mem_data_out unchanged, go to ACK.
//    READ, cnt!=0: decrement cnt.
//    READ, cnt==0: mem_data_out<=mem[addr_q]; mem_ack<=1; read_count+=1; go to ACK.
//    ACK: hold mem_ack=1 and mem_data_out until s_req=0 and s_ghost=0;
//      then mem_ack<=0 and go to IDLE. No new request is accepted in the same cycle.
//  - Latency, counted from the IDLE edge that samples the request:
//    read: mem_ack high after READ_LATENCY+1 edges; ghost: mem_ack high after 1 edge.
//  - mem_addr_in is sampled only on the IDLE->READ edge; changes after that are ignored.
//  - Load port: mem[load_addr]<=load_data on any edge with load_en=1, in any state.
//    A read at the same edge returns the old word; a write on an earlier edge is visible.
//  - read_count wraps from 2**COUNT_WIDTH-1 to 0. Ghost requests do not count.
//  - proto_err is cleared only by rst.
//  - Reset mid-handshake: mem_ack drops on the reset edge and the FSM returns to IDLE.
//    The initiator must lower its request and re-issue.
// CONFIGURATION
//  MEM_RESP_SYNC_EN defined:
//    mem_req and mem_req_ghost each pass through a 2-flop synchronizer.
//    s_req/s_ghost lag the pins by 2 edges, adding 2 cycles per handshake phase.
//  MEM_RESP_SYNC_EN undefined:
//    s_req=mem_req and s_ghost=mem_req_ghost directly.
//    For fully synchronous benches; inputs must meet setup to clk.
// STRUCTURE
//  - Package mem_resp_pkg: typedef enum logic [1:0] {IDLE, READ, ACK} mem_resp_state_t;
//    also default DATA_WIDTH/ADDR_WIDTH localparams shared with data_path.
//  - Sub-module sync_2ff (1-bit, reset to 0), instantiated twice under MEM_RESP_SYNC_EN.
// TESTING (sync off unless noted; READ_LATENCY=2)
//  1. Load mem[5]=16'hBEEF; req with addr=5.
//     -> ack after 3 edges, data=16'hBEEF, read_count=1; req low -> ack low 1 edge later.
//  2. Ghost request after test 1.
//     -> ack after 1 edge, data stays 16'hBEEF, read_count stays 1.
//  3. req and ghost both high.
//     -> proto_err=1 permanently, ack stays 0, busy=0.
//  4. Change addr 5->7 during READ.
//     -> data returns mem[5].
//  5. Load mem[5]=16'h1234 at the same edge as the READ->ACK transition.
//     -> data=16'hBEEF; next read of addr 5 returns 16'h1234.
//  6. rst while in ACK.
//     -> all outputs 0 next edge; 256 reads with COUNT_WIDTH=8 -> read_count wraps to 0.
//     Repeat test 1 with MEM_RESP_SYNC_EN -> ack after 5 edges.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state type and default widths for the memory responder and data path
package mem_resp_pkg;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 4;
  typedef enum logic [1:0] {IDLE, READ, ACK} mem_resp_state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: 4-phase bundled-data memory request channel
interface mem_responder_if #(
  parameter int DATA_WIDTH = mem_resp_pkg::MEM_DATA_W,
  parameter int ADDR_WIDTH = mem_resp_pkg::MEM_ADDR_W
);
  logic                  mem_req;
  logic                  mem_req_ghost;
  logic [ADDR_WIDTH-1:0] mem_addr_in;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_data_out;
  modport master (output mem_req, mem_req_ghost, mem_addr_in, input mem_ack, mem_data_out);
  modport slave (input mem_req, mem_req_ghost, mem_addr_in, output mem_ack, mem_data_out);
endinterface

// File: rtl/mem_responder_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: clocked memory responder for 4-phase read/ghost requests.
// Define MEM_RESP_SYNC_EN to pass the request pins through 2-flop synchronizers.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_W,
  parameter int ADDR_WIDTH   = MEM_ADDR_W,
  parameter int READ_LATENCY = 2,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_responder_if.slave         mem,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   busy,
  output logic                   proto_err,
  output logic [COUNT_WIDTH-1:0] read_count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = 4;
  logic w_s_req, w_s_ghost;
`ifdef MEM_RESP_SYNC_EN
  sync_2ff u_sync_req (.clk(clk), .rst(rst), .i_d(mem.mem_req), .o_q(w_s_req));
  sync_2ff u_sync_ghost (.clk(clk), .rst(rst), .i_d(mem.mem_req_ghost), .o_q(w_s_ghost));
`else
  assign w_s_req   = mem.mem_req;
  assign w_s_ghost = mem.mem_req_ghost;
`endif
  mem_resp_state_t r_state, w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr_q;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_ack, r_proto;
  logic [COUNT_WIDTH-1:0] r_count;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_s_req & w_s_ghost) ? IDLE : w_s_req ? READ : w_s_ghost ? ACK : IDLE;
      READ:    w_next = (r_cnt == '0) ? ACK : READ;
      ACK:     w_next = (w_s_req | w_s_ghost) ? ACK : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_data   <= '0;
      r_ack    <= 1'b0;
      r_proto  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_s_req && w_s_ghost) r_proto <= 1'b1;
          else if (w_s_req) begin
            r_addr_q <= mem.mem_addr_in;
            r_cnt    <= CNT_W'(READ_LATENCY - 1);
          end else if (w_s_ghost) r_ack <= 1'b1;
        end
        READ: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_data  <= r_mem[r_addr_q];
            r_ack   <= 1'b1;
            r_count <= r_count + COUNT_WIDTH'(1);
          end
        end
        ACK: if (!w_s_req && !w_s_ghost) r_ack <= 1'b0;
        default: ;
      endcase
    end
  end
  // Storage is deliberately not reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end
  assign mem.mem_ack      = r_ack;
  assign mem.mem_data_out = r_data;
  assign busy             = (r_state != IDLE);
  assign proto_err        = r_proto;
  assign read_count       = r_count;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
module tb_mem_responder;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam int SD = `ifdef MEM_RESP_SYNC_EN 2 `else 0 `endif;
  logic clk = 1'b0;
  logic rst;
  logic load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic busy, proto_err;
  logic [CW-1:0] read_count;
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();
  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mem(mif.slave), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy), .proto_err(proto_err), .read_count(read_count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit full);
    mif.mem_req = 1'b1; mif.mem_addr_in = a;
    for (int i = 1; i < SD + 3; i++) begin
      tick();
      if (full) chk("rd_ack_early", 32'(mif.mem_ack), 0);
    end
    tick();
    if (full) begin
      chk("rd_ack", 32'(mif.mem_ack), 1);
      chk("rd_data", 32'(mif.mem_data_out), 32'(d));
      chk("rd_count", 32'(read_count), 32'(c));
    end
    mif.mem_req = 1'b0;
    for (int i = 0; i < SD; i++) tick();
    tick();
    if (full) chk("rd_ack_drop", 32'(mif.mem_ack), 0);
  endtask
  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    mif.mem_req = 1'b0; mif.mem_req_ghost = 1'b0; mif.mem_addr_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ack", 32'(mif.mem_ack), 0);
    chk("rst_data", 32'(mif.mem_data_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_proto", 32'(proto_err), 0);
    chk("rst_count", 32'(read_count), 0);
    load(4'd5, 16'hBEEF);
    load(4'd7, 16'h7777);
    rd(4'd5, 16'hBEEF, 8'd1, 1'b1);
    mif.mem_req_ghost = 1'b1;
    for (int i = 0; i < SD; i++) tick();
    tick();
    chk("ghost_ack", 32'(mif.mem_ack), 1);
    chk("ghost_busy", 32'(busy), 1);
    chk("ghost_data", 32'(mif.mem_data_out), 32'hBEEF);
    chk("ghost_count", 32'(read_count), 1);
    mif.mem_req_ghost = 1'b0;
    for (int i = 0; i < SD; i++) tick();
    tick();
    chk("ghost_drop", 32'(mif.mem_ack), 0);
    mif.mem_req = 1'b1; mif.mem_addr_in = 4'd5;
    for (int i = 0; i < SD + 1; i++) tick();
    chk("addr_busy", 32'(busy), 1);
    mif.mem_addr_in = 4'd7;
    tick(); tick();
    chk("addr_ack", 32'(mif.mem_ack), 1);
    chk("addr_data", 32'(mif.mem_data_out), 32'hBEEF);
    mif.mem_req = 1'b0;
    for (int i = 0; i < SD + 1; i++) tick();
    mif.mem_req = 1'b1; mif.mem_addr_in = 4'd5;
    for (int i = 0; i < SD + 2; i++) tick();
    load_en = 1'b1; load_addr = 4'd5; load_data = 16'h1234;
    tick();
    load_en = 1'b0;
    chk("wr_same_ack", 32'(mif.mem_ack), 1);
    chk("wr_same_data", 32'(mif.mem_data_out), 32'hBEEF);
    chk("wr_same_count", 32'(read_count), 3);
    mif.mem_req = 1'b0;
    for (int i = 0; i < SD + 1; i++) tick();
    rd(4'd5, 16'h1234, 8'd4, 1'b1);
    mif.mem_req = 1'b1; mif.mem_req_ghost = 1'b1;
    for (int i = 0; i < SD + 1; i++) tick();
    chk("proto_set", 32'(proto_err), 1);
    chk("proto_ack", 32'(mif.mem_ack), 0);
    chk("proto_busy", 32'(busy), 0);
    mif.mem_req = 1'b0; mif.mem_req_ghost = 1'b0;
    for (int i = 0; i < SD + 2; i++) tick();
    chk("proto_sticky", 32'(proto_err), 1);
    chk("proto_count", 32'(read_count), 4);
    mif.mem_req_ghost = 1'b1;
    for (int i = 0; i < SD + 1; i++) tick();
    chk("pre_rst_ack", 32'(mif.mem_ack), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mif.mem_req_ghost = 1'b0;
    chk("mid_rst_ack", 32'(mif.mem_ack), 0);
    chk("mid_rst_data", 32'(mif.mem_data_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_proto", 32'(proto_err), 0);
    chk("mid_rst_count", 32'(read_count), 0);
    tick();
    for (int i = 0; i < 255; i++) rd(4'd5, 16'h1234, 8'd0, 1'b0);
    chk("count_255", 32'(read_count), 255);
    rd(4'd5, 16'h1234, 8'd0, 1'b1);
    chk("count_wrap_busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
